// File: rtl/cordic_vectoring.sv
`default_nettype none
// ============================================================================
// Module   : cordic_vectoring
// Desc     : Pipelined vectoring-mode CORDIC, I/Q -> magnitude/phase, one
//            sample per clock. Define CORDIC_PHASE_DIFF_EN to build the
//            phase-difference (FM discriminator) path on out_dphase.
// Revision : 1.0  initial release
// ============================================================================
module cordic_vectoring #(
    parameter int IN_WIDTH    = 16,
    parameter int EXTRA_BITS  = 5,
    parameter int MAG_WIDTH   = 16,
    parameter int PHASE_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [IN_WIDTH-1:0]    in_data_I,
    input  logic [IN_WIDTH-1:0]    in_data_Q,
    output logic                   out_valid,
    output logic [MAG_WIDTH-1:0]   out_mag,
    output logic [PHASE_WIDTH-1:0] out_phase,
    output logic [PHASE_WIDTH-1:0] out_dphase
);
    localparam int c_WR  = IN_WIDTH + EXTRA_BITS + 2;
    localparam int c_WZ  = IN_WIDTH + EXTRA_BITS - 1;
    localparam int c_STG = IN_WIDTH + EXTRA_BITS - 2;
    localparam logic signed [c_WZ-1:0] c_PI_2 = {2'b01, {(c_WZ-2){1'b0}}};

    // atan(2^-s) with 2^32 = 2*Pi (truncated), then rounded to c_WZ bits
    function automatic logic signed [c_WZ-1:0] atan_const(input int s);
        logic [63:0] v;
        case (s)
            0:  v = 64'd536870912;
            1:  v = 64'd316933406;
            2:  v = 64'd167458907;
            3:  v = 64'd85004756;
            4:  v = 64'd42667331;
            5:  v = 64'd21354465;
            6:  v = 64'd10679838;
            7:  v = 64'd5340245;
            8:  v = 64'd2670163;
            9:  v = 64'd1335087;
            10: v = 64'd667544;
            11: v = 64'd333772;
            12: v = 64'd166886;
            13: v = 64'd83443;
            14: v = 64'd41721;
            15: v = 64'd20860;
            16: v = 64'd10430;
            17: v = 64'd5215;
            18: v = 64'd2607;
            19: v = 64'd1303;
            20: v = 64'd651;
            21: v = 64'd325;
            22: v = 64'd162;
            23: v = 64'd81;
            24: v = 64'd40;
            25: v = 64'd20;
            26: v = 64'd10;
            27: v = 64'd5;
            28: v = 64'd2;
            29: v = 64'd1;
            default: v = 64'd0;
        endcase
        v = (v + (64'd1 << (31 - c_WZ))) >> (32 - c_WZ);
        return $signed(v[c_WZ-1:0]);
    endfunction

    // Half an LSB at shift s; adding it before >>> gives round-half-up
    function automatic logic signed [c_WR-1:0] round_half(input int s);
        logic [c_WR-1:0] v;
        v = {{(c_WR-1){1'b0}}, 1'b1} << s;
        return $signed(v >> 1);
    endfunction

    logic signed [c_WR-1:0] w_xi;
    logic signed [c_WR-1:0] w_yi;
    logic                   w_zero_in;

    assign w_xi      = {{2{in_data_I[IN_WIDTH-1]}}, in_data_I, {EXTRA_BITS{1'b0}}};
    assign w_yi      = {{2{in_data_Q[IN_WIDTH-1]}}, in_data_Q, {EXTRA_BITS{1'b0}}};
    assign w_zero_in = (in_data_I == '0) && (in_data_Q == '0);

    logic signed [c_WR-1:0] r_x [0:c_STG-1];
    logic signed [c_WR-1:0] r_y [0:c_STG-1];
    logic signed [c_WZ-1:0] r_z [0:c_STG-1];
    logic [c_STG-1:0]       r_vld;
    logic [c_STG-1:0]       r_zero;

    logic signed [c_WR-1:0] w_xs   [1:c_STG-1];
    logic signed [c_WR-1:0] w_ys   [1:c_STG-1];
    logic signed [c_WZ-1:0] w_atan [1:c_STG-1];

    always_comb begin
        for (int n = 1; n < c_STG; n++) begin
            w_xs[n]   = (r_x[n-1] + round_half(n-1)) >>> (n-1);
            w_ys[n]   = (r_y[n-1] + round_half(n-1)) >>> (n-1);
            w_atan[n] = atan_const(n-1);
        end
    end

    // Valid and zero flags ride alongside the data; only valid needs clearing
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld  <= '0;
            r_zero <= '0;
        end else begin
            r_vld  <= {r_vld[c_STG-2:0], in_valid};
            r_zero <= {r_zero[c_STG-2:0], w_zero_in};
        end
    end

    always_ff @(posedge clock) begin
        // Fold left half-plane onto right half-plane by a +/-Pi/2 rotation
        if (!w_xi[c_WR-1]) begin
            r_x[0] <= w_xi;
            r_y[0] <= w_yi;
            r_z[0] <= '0;
        end else if (!w_yi[c_WR-1]) begin
            r_x[0] <= w_yi;
            r_y[0] <= -w_xi;
            r_z[0] <= c_PI_2;
        end else begin
            r_x[0] <= -w_yi;
            r_y[0] <= w_xi;
            r_z[0] <= -c_PI_2;
        end
        for (int n = 1; n < c_STG; n++) begin
            if (!r_y[n-1][c_WR-1]) begin
                r_x[n] <= r_x[n-1] + w_ys[n];
                r_y[n] <= r_y[n-1] - w_xs[n];
                r_z[n] <= r_z[n-1] + w_atan[n];
            end else begin
                r_x[n] <= r_x[n-1] - w_ys[n];
                r_y[n] <= r_y[n-1] + w_xs[n];
                r_z[n] <= r_z[n-1] - w_atan[n];
            end
        end
    end

    logic [c_WR-1:0]        w_xf;
    logic [c_WZ-1:0]        w_zf;
    logic [MAG_WIDTH:0]     w_mag_sum;
    logic [MAG_WIDTH-1:0]   w_mag;
    logic [PHASE_WIDTH-1:0] w_phase;
    logic [MAG_WIDTH-1:0]   w_mag_o;
    logic [PHASE_WIDTH-1:0] w_phase_o;
    logic                   w_unused;

    assign w_xf      = r_x[c_STG-1];
    assign w_zf      = r_z[c_STG-1];
    assign w_mag_sum = {1'b0, w_xf[c_WR-2 -: MAG_WIDTH]}
                     + {{MAG_WIDTH{1'b0}}, w_xf[c_WR-2-MAG_WIDTH]};
    assign w_mag     = w_mag_sum[MAG_WIDTH] ? {MAG_WIDTH{1'b1}} : w_mag_sum[MAG_WIDTH-1:0];
    // Phase rounding wraps naturally, so +Pi rounds into -Pi (0x8000)
    assign w_phase   = w_zf[c_WZ-1 -: PHASE_WIDTH]
                     + {{(PHASE_WIDTH-1){1'b0}}, w_zf[c_WZ-1-PHASE_WIDTH]};
    assign w_mag_o   = r_zero[c_STG-1] ? '0 : w_mag;
    assign w_phase_o = r_zero[c_STG-1] ? '0 : w_phase;
    assign w_unused  = ^{w_xf[c_WR-1], w_xf[c_WR-3-MAG_WIDTH:0],
                         w_zf[c_WZ-2-PHASE_WIDTH:0], r_y[c_STG-1]};

    logic                   r_valid;
    logic [MAG_WIDTH-1:0]   r_mag;
    logic [PHASE_WIDTH-1:0] r_phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_mag   <= '0;
            r_phase <= '0;
        end else begin
            r_valid <= r_vld[c_STG-1];
            if (r_vld[c_STG-1]) begin
                r_mag   <= w_mag_o;
                r_phase <= w_phase_o;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_mag   = r_mag;
    assign out_phase = r_phase;

`ifdef CORDIC_PHASE_DIFF_EN
    logic [PHASE_WIDTH-1:0] r_prev_phase;
    logic [PHASE_WIDTH-1:0] r_dphase;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_phase <= '0;
            r_dphase     <= '0;
        end else if (r_vld[c_STG-1]) begin
            r_dphase     <= w_phase_o - r_prev_phase;
            r_prev_phase <= w_phase_o;
        end
    end

    assign out_dphase = r_dphase;
`else
    assign out_dphase = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_vectoring
// Desc     : Directed self-checking bench for cordic_vectoring.
// Revision : 1.0  initial release
// ============================================================================
module tb_cordic_vectoring;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data_I;
    logic [15:0] in_data_Q;
    logic        out_valid;
    logic [15:0] out_mag;
    logic [15:0] out_phase;
    logic [15:0] out_dphase;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          q_cyc[$];
    logic [15:0] q_mag[$];
    logic [15:0] q_ph[$];
    logic [15:0] q_dph[$];
    int          rst_watch = -1;
    logic        ov_at_rst = 1'bx;

    // Eight axis/diagonal vectors with their exact phases
    int          t_i[8]  = '{16384, 0, -16384, 0, 11585, -11585, -11585, 11585};
    int          t_q[8]  = '{0, 16384, 0, -16384, 11585, 11585, -11585, -11585};
    logic [15:0] t_ph[8] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000,
                             16'h2000, 16'h6000, 16'hA000, 16'hE000};
    // 14000*cos(k*Pi/8), k = 0..15; sin(k*Pi/8) = cos((k+12)*Pi/8)
    int          t_cos[16] = '{14000, 12934, 9900, 5358, 0, -5358, -9900, -12934,
                               -14000, -12934, -9900, -5358, 0, 5358, 9900, 12934};

    cordic_vectoring dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data_I  (in_data_I),
        .in_data_Q  (in_data_Q),
        .out_valid  (out_valid),
        .out_mag    (out_mag),
        .out_phase  (out_phase),
        .out_dphase (out_dphase)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (out_valid === 1'b1) begin
            q_cyc.push_back(cyc);
            q_mag.push_back(out_mag);
            q_ph.push_back(out_phase);
            q_dph.push_back(out_dphase);
        end
        if (cyc == rst_watch) ov_at_rst = out_valid;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int ph_err(input logic [15:0] a, input logic [15:0] b);
        logic signed [15:0] d;
        d = a - b;
        return (d < 0) ? -int'(d) : int'(d);
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_q();
        q_cyc.delete();
        q_mag.delete();
        q_ph.delete();
        q_dph.delete();
    endtask

    task automatic wait_outs(input int n, input int budget);
        int t = 0;
        while (q_cyc.size() < n && t < budget) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data_I = '0; in_data_Q = '0;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_mag !== 16'h0) begin failures++; $display("FAIL reset_mag got=%h exp=0", out_mag); end
        checks++; if (out_phase !== 16'h0) begin failures++; $display("FAIL reset_phase got=%h exp=0", out_phase); end
        checks++; if (out_dphase !== 16'h0) begin failures++; $display("FAIL reset_dphase got=%h exp=0", out_dphase); end
        clear_q();
        reset = 1'b0;
        repeat (25) tick();
        checks++; if (q_cyc.size() != 0) begin failures++; $display("FAIL idle_outputs got=%0d exp=0", q_cyc.size()); end
        checks++; if (out_mag !== 16'h0) begin failures++; $display("FAIL idle_mag got=%h exp=0", out_mag); end
    endtask

    task automatic test_single();
        int sent;
        clear_q();
        tick();
        in_valid = 1'b1; in_data_I = 16'd16384; in_data_Q = 16'd0; sent = cyc;
        tick();
        in_valid = 1'b0;
        wait_outs(1, 40);
        repeat (5) tick();
        checks++; if (q_cyc.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", q_cyc.size()); end
        if (q_cyc.size() > 0) begin
            checks++; if (q_cyc[0] - sent != 20) begin failures++; $display("FAIL single_latency got=%0d exp=20", q_cyc[0] - sent); end
            checks++; if (ph_err(q_ph[0], 16'h0000) > 1) begin failures++; $display("FAIL single_phase got=%h exp=0000+/-1", q_ph[0]); end
            checks++; if (abs_i(int'(q_mag[0]) - 13490) > 2) begin failures++; $display("FAIL single_mag got=%0d exp=13490+/-2", q_mag[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        int vi[4] = '{0, -16384, 0, 11585};
        int vq[4] = '{16384, 0, -16384, 11585};
        logic [15:0] vp[4] = '{16'h4000, 16'h8000, 16'hC000, 16'h2000};
        clear_q();
        tick();
        sent = cyc;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            in_valid = 1'b1; in_data_I = 16'(vi[k]); in_data_Q = 16'(vq[k]);
        end
        tick();
        in_valid = 1'b0;
        wait_outs(4, 40);
        repeat (3) tick();
        checks++; if (q_cyc.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", q_cyc.size()); end
        if (q_cyc.size() > 0) begin
            checks++; if (q_cyc[0] - sent != 20) begin failures++; $display("FAIL b2b_latency got=%0d exp=20", q_cyc[0] - sent); end
        end
        for (int k = 0; k < 4 && k < q_cyc.size(); k++) begin
            checks++; if (q_cyc[k] != q_cyc[0] + k) begin failures++; $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", k, q_cyc[k], q_cyc[0] + k); end
            checks++; if (ph_err(q_ph[k], vp[k]) > 1) begin failures++; $display("FAIL b2b_phase[%0d] got=%h exp=%h+/-1", k, q_ph[k], vp[k]); end
            checks++; if (abs_i(int'(q_mag[k]) - 13490) > 3) begin failures++; $display("FAIL b2b_mag[%0d] got=%0d exp=13490+/-3", k, q_mag[k]); end
        end
    endtask

    task automatic test_corners();
        clear_q();
        tick();
        in_valid = 1'b1; in_data_I = 16'h0000; in_data_Q = 16'h0000;
        tick();
        in_data_I = 16'h8000; in_data_Q = 16'h8000;
        tick();
        in_valid = 1'b0;
        wait_outs(2, 40);
        repeat (3) tick();
        checks++; if (q_cyc.size() != 2) begin failures++; $display("FAIL corner_count got=%0d exp=2", q_cyc.size()); end
        if (q_cyc.size() > 1) begin
            checks++; if (q_mag[0] !== 16'd0) begin failures++; $display("FAIL zero_mag got=%0d exp=0", q_mag[0]); end
            checks++; if (q_ph[0] !== 16'h0000) begin failures++; $display("FAIL zero_phase got=%h exp=0000", q_ph[0]); end
            checks++; if (ph_err(q_ph[1], 16'hA000) > 1) begin failures++; $display("FAIL fullneg_phase got=%h exp=A000+/-1", q_ph[1]); end
            checks++; if (abs_i(int'(q_mag[1]) - 38156) > 4) begin failures++; $display("FAIL fullneg_mag got=%0d exp=38156+/-4", q_mag[1]); end
        end
    endtask

    function automatic int count_post(input int rc);
        int n = 0;
        foreach (q_cyc[j]) if (q_cyc[j] > rc) n++;
        return n;
    endfunction

    task automatic test_reset_midstream();
        int s_cyc[$];
        int s_idx[$];
        int rc = 0;
        int gap;
        int t = 0;
        int p = 0;
        clear_q();
        for (int k = 0; k < 30; k++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                tick();
                in_valid = 1'b0; reset = 1'b0;
            end
            tick();
            reset = (k == 10); in_valid = 1'b1;
            in_data_I = 16'(t_i[k % 8]); in_data_Q = 16'(t_q[k % 8]);
            if (k == 10) begin
                rc = cyc + 1;
                rst_watch = rc;
            end else if (k > 10) begin
                s_cyc.push_back(cyc);
                s_idx.push_back(k);
            end
        end
        tick();
        in_valid = 1'b0; reset = 1'b0;
        while (count_post(rc) < s_cyc.size() && t < 200) begin
            tick();
            t++;
        end
        repeat (25) tick();
        checks++; if (ov_at_rst !== 1'b0) begin failures++; $display("FAIL midrst_valid_after_reset got=%b exp=0", ov_at_rst); end
        checks++; if (count_post(rc) != s_cyc.size()) begin failures++; $display("FAIL midrst_count got=%0d exp=%0d", count_post(rc), s_cyc.size()); end
        foreach (q_cyc[j]) begin
            if (q_cyc[j] > rc && p < s_cyc.size()) begin
                checks++; if (q_cyc[j] - s_cyc[p] != 20) begin failures++; $display("FAIL midrst_latency[%0d] got=%0d exp=20", s_idx[p], q_cyc[j] - s_cyc[p]); end
                checks++; if (ph_err(q_ph[j], t_ph[s_idx[p] % 8]) > 1) begin failures++; $display("FAIL midrst_phase[%0d] got=%h exp=%h+/-1", s_idx[p], q_ph[j], t_ph[s_idx[p] % 8]); end
                p++;
            end
        end
        rst_watch = -1;
    endtask

    task automatic test_phase_diff();
        logic [15:0] exp_ph;
        logic [15:0] exp_dp;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        clear_q();
        for (int k = 0; k < 20; k++) begin
            tick();
            in_valid = 1'b1;
            in_data_I = 16'(t_cos[k % 16]);
            in_data_Q = 16'(t_cos[(k + 12) % 16]);
        end
        tick();
        in_valid = 1'b0;
        wait_outs(20, 60);
        repeat (3) tick();
        checks++; if (q_cyc.size() != 20) begin failures++; $display("FAIL pdiff_count got=%0d exp=20", q_cyc.size()); end
        for (int k = 0; k < 20 && k < q_cyc.size(); k++) begin
            exp_ph = 16'(k * 4096);
            checks++; if (ph_err(q_ph[k], exp_ph) > 2) begin failures++; $display("FAIL pdiff_phase[%0d] got=%h exp=%h+/-2", k, q_ph[k], exp_ph); end
`ifdef CORDIC_PHASE_DIFF_EN
            exp_dp = (k == 0) ? 16'h0000 : 16'h1000;
            checks++; if (ph_err(q_dph[k], exp_dp) > 2) begin failures++; $display("FAIL pdiff_dphase[%0d] got=%h exp=%h+/-2", k, q_dph[k], exp_dp); end
`else
            exp_dp = 16'h0000;
            checks++; if (q_dph[k] !== exp_dp) begin failures++; $display("FAIL pdiff_dphase_off[%0d] got=%h exp=%h", k, q_dph[k], exp_dp); end
`endif
        end
    endtask

    task automatic test_random();
        int ri[$];
        int rq[$];
        int a;
        int b;
        logic signed [15:0] s;
        real ang;
        real mexp;
        int pint;
        logic [15:0] pexp;
        int n = 1500;
        clear_q();
        for (int k = 0; k < n; k++) begin
            do begin
                s = 16'($urandom); a = int'(s);
                s = 16'($urandom); b = int'(s);
            end while (a > -2048 && a < 2048 && b > -2048 && b < 2048);
            ri.push_back(a);
            rq.push_back(b);
            tick();
            in_valid = 1'b1; in_data_I = 16'(a); in_data_Q = 16'(b);
        end
        tick();
        in_valid = 1'b0;
        wait_outs(n, n + 60);
        repeat (3) tick();
        checks++; if (q_cyc.size() != n) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", q_cyc.size(), n); end
        for (int j = 0; j < n && j < q_cyc.size(); j++) begin
            ang  = $atan2(real'(rq[j]), real'(ri[j]));
            pint = $rtoi($floor(ang * 65536.0 / (2.0 * 3.14159265358979) + 0.5));
            pexp = 16'(pint);
            mexp = $sqrt(real'(ri[j]) * real'(ri[j]) + real'(rq[j]) * real'(rq[j])) * 0.82338013;
            checks++; if (ph_err(q_ph[j], pexp) > 2) begin failures++; $display("FAIL rand_phase[%0d] I=%0d Q=%0d got=%h exp=%h+/-2", j, ri[j], rq[j], q_ph[j], pexp); end
            checks++; if ((real'(q_mag[j]) - mexp > 4.0) || (mexp - real'(q_mag[j]) > 4.0)) begin failures++; $display("FAIL rand_mag[%0d] I=%0d Q=%0d got=%0d exp=%0.1f+/-4", j, ri[j], rq[j], q_mag[j], mexp); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_corners();
        test_reset_midstream();
        test_phase_diff();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
